// File: rtl/regfile_wb_ctrl_pkg.sv
// regfile_wb_ctrl_pkg: shared widths, reset/write polarities and helpers for the write-back controller.
package regfile_wb_ctrl_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_REG  = '0;
    localparam logic [DATA_W-1:0] DATA_ZERO = '0;
    localparam logic RST_ENABLE   = 1'b0;
    localparam logic WRITE_ENABLE = 1'b1;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_wr_t;
    function automatic logic [NREG-1:0] reg_mask(input logic [ADDR_W-1:0] a);
        return {{(NREG-1){1'b0}}, 1'b1} << a;
    endfunction
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// regfile_wb_ctrl_if: issue, hazard, write-back source and register-file write signals.
interface regfile_wb_ctrl_if;
    import regfile_wb_ctrl_pkg::*;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic              iss_ready;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              a_valid;
    logic [ADDR_W-1:0] a_waddr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_waddr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    modport master (
        output iss_valid, iss_rd, rs1_addr, rs2_addr,
        output a_valid, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
        input  iss_ready, rs1_busy, rs2_busy, a_ready, b_ready,
        input  rf_we, rf_waddr, rf_wdata
    );
    modport slave (
        input  iss_valid, iss_rd, rs1_addr, rs2_addr,
        input  a_valid, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
        output iss_ready, rs1_busy, rs2_busy, a_ready, b_ready,
        output rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; on contention grants the side not granted last.
module rr_arb2
    import regfile_wb_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic prefer_b;

    always_comb begin
        gnt[0] = req[0] & (~req[1] | ~prefer_b);
        gnt[1] = req[1] & (~req[0] | prefer_b);
    end

    always_ff @(posedge clk) begin
        if (rst_n == RST_ENABLE)
            prefer_b <= 1'b0;
        else if (|gnt)
            prefer_b <= gnt[0];
    end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: arbitrates ALU (A) and load/mul-div (B) write-back onto the single
// register-file write port and keeps the busy scoreboard used for decode hazard checks.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    regfile_wb_ctrl_if.slave bus
);
    logic [1:0]      gnt;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_set;
    logic [NREG-1:0] busy_clr;
    wb_wr_t          win;
    logic            wr_fire;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({bus.b_valid, bus.a_valid}),
        .gnt   (gnt)
    );

    always_comb begin
        win = gnt[1] ? {bus.b_waddr, bus.b_wdata} : {bus.a_waddr, bus.a_wdata};
        wr_fire = |gnt && win.addr != ZERO_REG;
        bus.a_ready = gnt[0];
        bus.b_ready = gnt[1];
        bus.iss_ready = ~busy[bus.iss_rd];
        bus.rs1_busy = busy[bus.rs1_addr];
        bus.rs2_busy = busy[bus.rs2_addr];
        busy_set = (bus.iss_valid && ~busy[bus.iss_rd]) ? reg_mask(bus.iss_rd) : '0;
        busy_clr = wr_fire ? reg_mask(win.addr) : '0;
    end

    // Set is applied after clear so a new producer survives a same-cycle retire; x0 never sticks.
    always_ff @(posedge clk) begin
        if (rst_n == RST_ENABLE) begin
            busy         <= '0;
            bus.rf_we    <= ~WRITE_ENABLE;
            bus.rf_waddr <= ZERO_REG;
            bus.rf_wdata <= DATA_ZERO;
        end else begin
            busy      <= ((busy & ~busy_clr) | busy_set) & ~reg_mask(ZERO_REG);
            bus.rf_we <= wr_fire;
            if (wr_fire) begin
                bus.rf_waddr <= win.addr;
                bus.rf_wdata <= win.data;
            end
        end
    end

    wr_idle_reg: cover property (@(posedge clk) disable iff (rst_n == RST_ENABLE)
        wr_fire && !busy[win.addr]);
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed vectors with hand-computed expectations for regfile_wb_ctrl.
module tb_regfile_wb_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    regfile_wb_ctrl_if bus ();

    regfile_wb_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.iss_valid = 0; bus.iss_rd = 5; bus.rs1_addr = 5; bus.rs2_addr = 0;
        bus.a_valid = 0; bus.a_waddr = 0; bus.a_wdata = 0;
        bus.b_valid = 0; bus.b_waddr = 0; bus.b_wdata = 0;
        step();
        step();
        chk("rst_rf_we", 32'(bus.rf_we), 0);
        chk("rst_rf_waddr", 32'(bus.rf_waddr), 0);
        chk("rst_rf_wdata", bus.rf_wdata, 0);
        chk("rst_rs1_busy", 32'(bus.rs1_busy), 0);
        chk("rst_iss_ready", 32'(bus.iss_ready), 1);
        rst_n = 1;

        bus.iss_valid = 1; bus.iss_rd = 5;
        step();
        bus.iss_valid = 0;
        #1;
        chk("issue5_rs1_busy", 32'(bus.rs1_busy), 1);
        chk("issue5_waw_ready", 32'(bus.iss_ready), 0);

        bus.a_valid = 1; bus.a_waddr = 5; bus.a_wdata = 32'hDEADBEEF;
        #1;
        chk("a5_ready", 32'(bus.a_ready), 1);
        chk("a5_no_fwd_busy", 32'(bus.rs1_busy), 1);
        step();
        bus.a_valid = 0;
        #1;
        chk("a5_rf_we", 32'(bus.rf_we), 1);
        chk("a5_rf_waddr", 32'(bus.rf_waddr), 5);
        chk("a5_rf_wdata", bus.rf_wdata, 32'hDEADBEEF);
        chk("a5_busy_clr", 32'(bus.rs1_busy), 0);
        step();
        chk("a5_we_drop", 32'(bus.rf_we), 0);
        chk("a5_waddr_hold", 32'(bus.rf_waddr), 5);

        // A won last, so contention starts with B: B,A,B,A
        bus.a_valid = 1; bus.a_waddr = 1; bus.a_wdata = 32'h11;
        bus.b_valid = 1; bus.b_waddr = 2; bus.b_wdata = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d_a_ready", k), 32'(bus.a_ready), (k % 2 == 0) ? 0 : 1);
            chk($sformatf("rr%0d_b_ready", k), 32'(bus.b_ready), (k % 2 == 0) ? 1 : 0);
            if (k > 0) begin
                chk($sformatf("rr%0d_rf_we", k), 32'(bus.rf_we), 1);
                chk($sformatf("rr%0d_rf_waddr", k), 32'(bus.rf_waddr), (k % 2 == 0) ? 1 : 2);
            end
            step();
        end
        bus.a_valid = 0; bus.b_valid = 0;
        #1;
        chk("rr_last_we", 32'(bus.rf_we), 1);
        chk("rr_last_waddr", 32'(bus.rf_waddr), 1);
        chk("rr_last_wdata", bus.rf_wdata, 32'h11);

        bus.a_valid = 1; bus.a_waddr = 7; bus.a_wdata = 32'h77;
        bus.iss_valid = 1; bus.iss_rd = 7;
        #1;
        chk("set_clr_iss_ready", 32'(bus.iss_ready), 1);
        step();
        bus.a_valid = 0; bus.iss_valid = 0; bus.rs1_addr = 7;
        #1;
        chk("set_wins_busy7", 32'(bus.rs1_busy), 1);
        chk("set_clr_rf_waddr", 32'(bus.rf_waddr), 7);

        bus.b_valid = 1; bus.b_waddr = 0; bus.b_wdata = 32'h1234;
        bus.iss_rd = 0; bus.rs2_addr = 0;
        #1;
        chk("x0_b_ready", 32'(bus.b_ready), 1);
        chk("x0_iss_ready", 32'(bus.iss_ready), 1);
        chk("x0_rs2_busy", 32'(bus.rs2_busy), 0);
        step();
        bus.b_valid = 0;
        #1;
        chk("x0_rf_we", 32'(bus.rf_we), 0);
        chk("x0_waddr_hold", 32'(bus.rf_waddr), 7);
        chk("x0_wdata_hold", bus.rf_wdata, 32'h77);

        bus.iss_valid = 1; bus.iss_rd = 3;
        step();
        bus.iss_rd = 9;
        step();
        bus.iss_valid = 0; bus.rs1_addr = 3; bus.rs2_addr = 9;
        #1;
        chk("pre_rst_busy3", 32'(bus.rs1_busy), 1);
        chk("pre_rst_busy9", 32'(bus.rs2_busy), 1);
        bus.a_valid = 1; bus.a_waddr = 4; bus.a_wdata = 32'h44;
        step();
        bus.a_valid = 0;
        #1;
        chk("pre_rst_we", 32'(bus.rf_we), 1);
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
        chk("post_rst_busy3", 32'(bus.rs1_busy), 0);
        chk("post_rst_busy9", 32'(bus.rs2_busy), 0);
        chk("post_rst_rf_we", 32'(bus.rf_we), 0);
        chk("post_rst_rf_waddr", 32'(bus.rf_waddr), 0);
        bus.rs1_addr = 7;
        #1;
        chk("post_rst_busy7", 32'(bus.rs1_busy), 0);
        bus.a_valid = 1; bus.a_waddr = 1; bus.a_wdata = 32'hA1;
        bus.b_valid = 1; bus.b_waddr = 2; bus.b_wdata = 32'hB2;
        #1;
        chk("post_rst_a_first", 32'(bus.a_ready), 1);
        chk("post_rst_b_wait", 32'(bus.b_ready), 0);
        step();
        bus.a_valid = 0;
        #1;
        chk("post_rst_b_next", 32'(bus.b_ready), 1);
        chk("post_rst_rf_waddr_a", 32'(bus.rf_waddr), 1);
        chk("post_rst_rf_wdata_a", bus.rf_wdata, 32'hA1);
        step();
        bus.b_valid = 0;
        #1;
        chk("post_rst_rf_waddr_b", 32'(bus.rf_waddr), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
